// File: rtl/alu_wb_stage_pkg.sv
// ============================================================================
// Module : alu_wb_stage_pkg
// Shared FUNC encodings, default width and flag reset values.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_wb_stage_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    FUNC_ADD  = 2'b00,
    FUNC_ANDN = 2'b01,
    FUNC_OR   = 2'b10,
    FUNC_NOTB = 2'b11
  } func_e;

  localparam logic FLAG_C_RST = 1'b0;
  localparam logic FLAG_Z_RST = 1'b1;
  localparam logic FLAG_N_RST = 1'b0;

endpackage

`default_nettype wire

// File: rtl/alu_wb_stage_result_fifo2.sv
// ============================================================================
// Module : result_fifo2
// Two-entry result FIFO with registered full/empty flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module result_fifo2 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             w_push;
  logic             w_pop;

  // Guard against a caller that ignores full/empty.
  assign w_push = push_i & ~full_q;
  assign w_pop  = pop_i & ~empty_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    if (w_push) tail_d = ~tail_q;
    if (w_pop)  head_d = ~head_q;
    full_d  = (count_d == 2'(DEPTH));
    empty_d = (count_d == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (w_push) mem_q[tail_q] <= data_i;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign data_o  = mem_q[head_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

`default_nettype wire

// File: rtl/alu_wb_stage.sv
// ============================================================================
// Module : alu_wb_stage
// ALU writeback: C/Z/N flags, chained-add carry feed and 2-entry result skid.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             ALU_C_OUT,
  input  logic [1:0]       FUNC,
  input  logic             CHAIN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             CARRY_TO_ALU,
  output logic [WIDTH-1:0] RESULT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             FLAG_C,
  output logic             FLAG_Z,
  output logic             FLAG_N
);

  logic w_full;
  logic w_empty;
  logic w_push;
  logic flag_c_q, flag_c_d;
  logic flag_z_q, flag_z_d;
  logic flag_n_q, flag_n_d;

  assign IN_READY  = ~w_full;
  assign OUT_VALID = ~w_empty;
  assign w_push    = IN_VALID & IN_READY;

  result_fifo2 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .push_i  (w_push),
    .pop_i   (OUT_READY),
    .data_i  (ALU_OUT),
    .data_o  (RESULT),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Z accumulates across chained words so a multi-word result reads zero only if every word was.
  always_comb begin
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    if (w_push) begin
      flag_n_d = ALU_OUT[WIDTH-1];
      flag_z_d = (ALU_OUT == '0) & (~CHAIN | flag_z_q);
      if (FUNC == FUNC_ADD) flag_c_d = ALU_C_OUT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      flag_c_q <= FLAG_C_RST;
      flag_z_q <= FLAG_Z_RST;
      flag_n_q <= FLAG_N_RST;
    end else begin
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign CARRY_TO_ALU = CHAIN & flag_c_q;
  assign FLAG_C       = flag_c_q;
  assign FLAG_Z       = flag_z_q;
  assign FLAG_N       = flag_n_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
// ============================================================================
// Module : tb_alu_wb_stage
// Scoreboard bench for alu_wb_stage with directed and random traffic.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_wb_stage;

  logic        clk;
  logic        rst;
  logic [15:0] alu_out;
  logic        alu_c_out;
  logic [1:0]  func;
  logic        chain;
  logic        in_valid;
  logic        in_ready;
  logic        carry_to_alu;
  logic [15:0] result;
  logic        out_valid;
  logic        out_ready;
  logic        flag_c, flag_z, flag_n;

  int tests = 0;
  int fails = 0;

  logic [15:0] sb_q[$];
  logic        m_c = 1'b0, m_z = 1'b1, m_n = 1'b0;
  logic        pend_rst = 1'b1;
  logic        pend_push = 1'b0;
  logic [15:0] pend_val;
  logic        pend_cout;
  logic [1:0]  pend_func;
  logic        pend_chain;

  alu_wb_stage dut (
    .CLK          (clk),
    .RESET        (rst),
    .ALU_OUT      (alu_out),
    .ALU_C_OUT    (alu_c_out),
    .FUNC         (func),
    .CHAIN        (chain),
    .IN_VALID     (in_valid),
    .IN_READY     (in_ready),
    .CARRY_TO_ALU (carry_to_alu),
    .RESULT       (result),
    .OUT_VALID    (out_valid),
    .OUT_READY    (out_ready),
    .FLAG_C       (flag_c),
    .FLAG_Z       (flag_z),
    .FLAG_N       (flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes the scoreboard head whenever the DUT hands a result over.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) chk("unexpected_pop", 32'(result), 32'hDEAD_BEEF);
      else chk("result", 32'(result), 32'(sb_q.pop_front()));
    end
  end

  // One cycle: fold last cycle's outcome into the model, check, then drive new inputs.
  task automatic cyc(input logic r, input logic v, input logic [1:0] f, input logic ch,
                     input logic [15:0] ao, input logic co, input logic ordy);
    @(posedge clk);
    #1;
    if (pend_rst) begin
      sb_q.delete();
      m_c = 1'b0; m_z = 1'b1; m_n = 1'b0;
    end else if (pend_push) begin
      sb_q.push_back(pend_val);
      m_n = pend_val[15];
      m_z = (pend_val == 16'h0) && (!pend_chain || m_z);
      if (pend_func == 2'b00) m_c = pend_cout;
    end
    chk("in_ready",  32'(in_ready),  32'(sb_q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(sb_q.size() > 0));
    chk("flag_c", 32'(flag_c), 32'(m_c));
    chk("flag_z", 32'(flag_z), 32'(m_z));
    chk("flag_n", 32'(flag_n), 32'(m_n));
    rst = r; in_valid = v; func = f; chain = ch;
    alu_out = ao; alu_c_out = co; out_ready = ordy;
    pend_rst   = r;
    pend_push  = v && (sb_q.size() < 2);
    pend_val   = ao;
    pend_cout  = co;
    pend_func  = f;
    pend_chain = ch;
    #1;
    chk("carry_to_alu", 32'(carry_to_alu), 32'(ch && m_c));
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0, ordy);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; func = 2'b00; chain = 1'b0;
    alu_out = 16'h0; alu_c_out = 1'b0; out_ready = 1'b0;

    cyc(1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0);
    idle(1'b0, 1);
    chk("rst_result", 32'(result), 32'h0);

    // Single add
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'h8000, 1'b1, 1'b0);
    idle(1'b0, 1);
    chk("add_result", 32'(result), 32'h8000);
    chk("add_flags", {29'h0, flag_n, flag_z, flag_c}, 32'h5);
    idle(1'b1, 2);

    // Back-pressure: third word must be dropped
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'h0001, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'h0002, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'h0003, 1'b0, 1'b0);
    idle(1'b0, 1);
    chk("bp_full", 32'(in_ready), 32'h0);
    idle(1'b1, 3);

    // Streaming with simultaneous push/pop at occupancy 1
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'h1111, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'h2222, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'h3333, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Chained add, all-zero then nonzero upper word
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 2'b00, 1'b1, 16'h0000, 1'b0, 1'b1);
    idle(1'b1, 1);
    chk("chain_z", {30'h0, flag_z, flag_c}, 32'h2);
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 2'b00, 1'b1, 16'h0001, 1'b0, 1'b1);
    idle(1'b1, 1);
    chk("chain_nz", 32'(flag_z), 32'h0);

    // Logic ops leave C alone
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'h1234, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 2'b01, 1'b0, 16'h00F0, 1'b0, 1'b1);
    idle(1'b1, 1);
    chk("logic_keeps_c", 32'(flag_c), 32'h1);

    // Reset with a full FIFO and a pending chained push
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'hABCD, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 2'b00, 1'b1, 16'h5555, 1'b1, 1'b1);
    idle(1'b0, 1);
    chk("rst_mid_valid", 32'(out_valid), 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ao;
      ao = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ao,
          1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
    end

    idle(1'b1, 4);
    chk("drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
